jtag_dr_bridge: RTL

Parametrised JTAG user-data-register bridge between the ECP5 `JTAGG` primitive and the SoC fabric. Samples the slow, asynchronous TCK domain in the fast system clock. Supports NUM_CHAN user DRs of DR_WIDTH bits, each with capture (readback via TDO) and shift. Delivers completed writes to the SoC debug register path through a valid/ready handshake with overrun reporting.

---
 rtl/jtag_dr_bridge.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/jtag_dr_bridge.sv
// jtag_dr_bridge: bridges the ECP5 JTAGG user data registers into the clk domain.
// The TCK domain is oversampled: every JTAG input goes through a synchroniser and
// TCK edges become single-cycle events that drive capture, shift and update of a
// DR_WIDTH shift register. Completed DR writes leave through a valid/ready port.
//
// Ports:
//   clk, rstn          system clock, async active-low reset
//   jtck, jtdi         raw JTAGG TCK / TDI (async to clk)
//   jshift, jupdate    raw JTAGG Shift-DR / Update-DR indications
//   jrstn              raw JTAGG TAP reset (active low)
//   jce[NUM_CHAN]      per-channel DR select, bit 0 = JCE1
//   jtdo[NUM_CHAN]     per-channel TDO back to JTAGG
//   cap_data           readback word per channel, channel k at [k*DR_WIDTH +: DR_WIDTH]
//   upd_data/upd_sel   last completed DR write and its channel
//   upd_valid/ready    handshake for upd_data/upd_sel
//   upd_overrun        one-cycle pulse when a pending word is overwritten
module jtag_dr_bridge #(
  parameter int unsigned DR_WIDTH    = 32,
  parameter int unsigned NUM_CHAN    = 2,
  parameter int unsigned SYNC_STAGES = 3,
  localparam int unsigned SELW       = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         jtck,
  input  logic                         jtdi,
  input  logic                         jshift,
  input  logic                         jupdate,
  input  logic                         jrstn,
  input  logic [NUM_CHAN-1:0]          jce,
  output logic [NUM_CHAN-1:0]          jtdo,
  input  logic [NUM_CHAN*DR_WIDTH-1:0] cap_data,
  output logic [DR_WIDTH-1:0]          upd_data,
  output logic [SELW-1:0]              upd_sel,
  output logic                         upd_valid,
  input  logic                         upd_ready,
  output logic                         upd_overrun
);

  localparam int unsigned IN_W    = 5 + NUM_CHAN;
  localparam int unsigned B_TCK   = 0;
  localparam int unsigned B_TDI   = 1;
  localparam int unsigned B_SHIFT = 2;
  localparam int unsigned B_UPD   = 3;
  localparam int unsigned B_JRSTN = 4;
  localparam int unsigned B_JCE   = 5;

  logic [IN_W-1:0] sync_q [SYNC_STAGES];
  logic [IN_W-1:0] s_in;

  logic                tck_rise, tck_fall;
  logic                s_jtdi, s_jshift, s_jupdate, s_jrstn;
  logic [NUM_CHAN-1:0] s_jce;

  logic [DR_WIDTH-1:0] sr_q, sr_nxt;
  logic [SELW-1:0]     sel_q, sel_nxt;
  logic                shift_q, shift_nxt;
  logic                cap_busy_q, cap_busy_nxt;
  logic                tdo_q, tdo_nxt;
  logic [NUM_CHAN-1:0] jtdo_nxt;
  logic [DR_WIDTH-1:0] upd_data_nxt;
  logic [SELW-1:0]     upd_sel_nxt;
  logic                upd_valid_nxt, upd_overrun_nxt;

  logic                cap_found;
  logic [SELW-1:0]     cap_k;
  logic [DR_WIDTH-1:0] cap_word;

  // Synchroniser chain for all JTAG inputs; stage SYNC_STAGES-1 is the oldest.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {jce, jrstn, jupdate, jshift, jtdi, jtck};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s_in      = sync_q[SYNC_STAGES-1];
  assign s_jtdi    = s_in[B_TDI];
  assign s_jshift  = s_in[B_SHIFT];
  assign s_jupdate = s_in[B_UPD];
  assign s_jrstn   = s_in[B_JRSTN];
  assign s_jce     = s_in[B_JCE +: NUM_CHAN];

  // Edge events from the two oldest stages: s_tck is about to take the newer value.
  assign tck_rise = sync_q[SYNC_STAGES-2][B_TCK] & ~s_in[B_TCK];
  assign tck_fall = ~sync_q[SYNC_STAGES-2][B_TCK] & s_in[B_TCK];

  // Lowest selected channel wins the capture.
  always_comb begin
    cap_found = 1'b0;
    cap_k     = '0;
    cap_word  = '0;
    for (int unsigned k = 0; k < NUM_CHAN; k++) begin
      if (s_jce[k] && !cap_found) begin
        cap_found = 1'b1;
        cap_k     = SELW'(k);
        cap_word  = cap_data[k*DR_WIDTH +: DR_WIDTH];
      end
    end
  end

  // Next-state: TCK events, handshake and overrun.
  always_comb begin
    sr_nxt          = sr_q;
    sel_nxt         = sel_q;
    shift_nxt       = shift_q;
    cap_busy_nxt    = cap_busy_q;
    tdo_nxt         = tdo_q;
    upd_data_nxt    = upd_data;
    upd_sel_nxt     = upd_sel;
    upd_valid_nxt   = upd_valid;
    upd_overrun_nxt = 1'b0;

    if (upd_valid && upd_ready) upd_valid_nxt = 1'b0;

    if (tck_rise) begin
      if (!s_jrstn) begin
        sr_nxt       = '0;
        sel_nxt      = '0;
        shift_nxt    = 1'b0;
        cap_busy_nxt = 1'b0;
      end else begin
        if (shift_q) begin
          sr_nxt = {s_jtdi, sr_q[DR_WIDTH-1:1]};
        end else if (cap_found && !s_jshift && !cap_busy_q) begin
          sr_nxt       = cap_word;
          sel_nxt      = cap_k;
          cap_busy_nxt = 1'b1;
        end
        if (s_jupdate) begin
          // A same-cycle accept hands over the old word, so only a stalled word overruns.
          upd_data_nxt    = sr_q;
          upd_sel_nxt     = sel_q;
          upd_valid_nxt   = 1'b1;
          upd_overrun_nxt = upd_valid && !upd_ready;
          cap_busy_nxt    = 1'b0;
        end
        shift_nxt = s_jshift;
      end
    end

    if (tck_fall) tdo_nxt = sr_q[0];

    // jtdo is registered from the next tdo/sel so it always equals tdo_q gated by sel.
    for (int unsigned k = 0; k < NUM_CHAN; k++) begin
      jtdo_nxt[k] = tdo_nxt && (sel_nxt == SELW'(k));
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_q        <= '0;
      sel_q       <= '0;
      shift_q     <= 1'b0;
      cap_busy_q  <= 1'b0;
      tdo_q       <= 1'b0;
      jtdo        <= '0;
      upd_data    <= '0;
      upd_sel     <= '0;
      upd_valid   <= 1'b0;
      upd_overrun <= 1'b0;
    end else begin
      sr_q        <= sr_nxt;
      sel_q       <= sel_nxt;
      shift_q     <= shift_nxt;
      cap_busy_q  <= cap_busy_nxt;
      tdo_q       <= tdo_nxt;
      jtdo        <= jtdo_nxt;
      upd_data    <= upd_data_nxt;
      upd_sel     <= upd_sel_nxt;
      upd_valid   <= upd_valid_nxt;
      upd_overrun <= upd_overrun_nxt;
    end
  end

endmodule
